jtag_tap: RTL

IEEE 1149.1 Test Access Port controller with parametrised IR length and a configurable number of user data registers. It is the next-generation debug front end for the CPU cores. It sits between the JTAG pins, which the DPI bit-bang driver feeds in simulation, and the core's debug logic. User registers expose parallel capture/update ports to the core.

---
 rtl/jtag_tap_pkg.sv | 62 ++++++
 rtl/jtag_tap_fsm.sv | 58 +++++
 rtl/jtag_tap.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared types and helpers for the JTAG TAP controller: TAP state encoding,
// the 1149.1 state transition function and IR_WIDTH-generic opcode helpers.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        ST_TLR      = 4'h0,
        ST_RTI      = 4'h1,
        ST_SEL_DR   = 4'h2,
        ST_CAP_DR   = 4'h3,
        ST_SH_DR    = 4'h4,
        ST_EX1_DR   = 4'h5,
        ST_PAUSE_DR = 4'h6,
        ST_EX2_DR   = 4'h7,
        ST_UPD_DR   = 4'h8,
        ST_SEL_IR   = 4'h9,
        ST_CAP_IR   = 4'hA,
        ST_SH_IR    = 4'hB,
        ST_EX1_IR   = 4'hC,
        ST_PAUSE_IR = 4'hD,
        ST_EX2_IR   = 4'hE,
        ST_UPD_IR   = 4'hF
    } tap_state_e;

    function automatic tap_state_e next_state(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        nxt = ST_TLR;
        case (state)
            ST_TLR:      nxt = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      nxt = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   nxt = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   nxt = tms ? ST_EX1_DR   : ST_SH_DR;
            ST_SH_DR:    nxt = tms ? ST_EX1_DR   : ST_SH_DR;
            ST_EX1_DR:   nxt = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: nxt = tms ? ST_EX2_DR   : ST_PAUSE_DR;
            ST_EX2_DR:   nxt = tms ? ST_UPD_DR   : ST_SH_DR;
            ST_UPD_DR:   nxt = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   nxt = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   nxt = tms ? ST_EX1_IR   : ST_SH_IR;
            ST_SH_IR:    nxt = tms ? ST_EX1_IR   : ST_SH_IR;
            ST_EX1_IR:   nxt = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: nxt = tms ? ST_EX2_IR   : ST_PAUSE_IR;
            ST_EX2_IR:   nxt = tms ? ST_UPD_IR   : ST_SH_IR;
            ST_UPD_IR:   nxt = tms ? ST_SEL_DR   : ST_RTI;
            default:     nxt = ST_TLR;
        endcase
        return nxt;
    endfunction

    // Opcodes are returned 32 bits wide; callers cast down to IR_WIDTH.
    function automatic logic [31:0] bypass_op(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    endfunction

    function automatic logic [31:0] idcode_op(input int width);
        return 32'h1 & bypass_op(width);
    endfunction

    function automatic logic [31:0] user_op(input int idx);
        return 32'(idx + 2);
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine with registered state and decoded
// capture/shift/update flags for the IR and DR paths.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic tck,
    input  logic trstn,
    input  logic tms,
    output logic test_logic_reset,
    output logic reset_next,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir
);
    // state       | meaning
    // ST_TLR      | test logic reset, instruction forced to reset opcode
    // ST_RTI      | run-test/idle
    // ST_SEL_*    | select DR/IR scan branch
    // ST_CAP_*    | parallel load of the selected shift register
    // ST_SH_*     | serial shift, tdo driven
    // ST_EX1/2_*  | exit states around pause
    // ST_PAUSE_*  | hold shift register contents
    // ST_UPD_*    | commit shift register to its parallel output

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) state_q <= ST_TLR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d          = next_state(state_q, tms);
        test_logic_reset = 1'b0;
        capture_dr       = 1'b0;
        shift_dr         = 1'b0;
        update_dr        = 1'b0;
        capture_ir       = 1'b0;
        shift_ir         = 1'b0;
        update_ir        = 1'b0;
        case (state_q)
            ST_TLR:    test_logic_reset = 1'b1;
            ST_CAP_DR: capture_dr       = 1'b1;
            ST_SH_DR:  shift_dr         = 1'b1;
            ST_UPD_DR: update_dr        = 1'b1;
            ST_CAP_IR: capture_ir       = 1'b1;
            ST_SH_IR:  shift_ir         = 1'b1;
            ST_UPD_IR: update_ir        = 1'b1;
            default:   ;
        endcase
        reset_next = (state_d == ST_TLR);
    end

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP top: IR and DR datapaths (bypass, optional IDCODE, user registers).
// Define JTAG_TAP_IDCODE_EN to include the IDCODE register and make it the reset instruction.
module jtag_tap
    import jtag_tap_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter int          NUM_DR     = 2,
    parameter int          DR_WIDTH   = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                         tck,
    input  logic                         trstn,
    input  logic                         tms,
    input  logic                         tdi,
    output logic                         tdo,
    output logic                         tdo_en,
    output logic [IR_WIDTH-1:0]          ir_out,
    input  logic [NUM_DR*DR_WIDTH-1:0]   dr_capture_data,
    output logic [DR_WIDTH-1:0]          dr_update_data,
    output logic [NUM_DR-1:0]            dr_update_valid,
    output logic                         tap_reset
);
    localparam logic [IR_WIDTH-1:0] OP_BYPASS  = IR_WIDTH'(bypass_op(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(idcode_op(IR_WIDTH));
    localparam logic [IR_WIDTH-1:0] RESET_OP   = OP_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] RESET_OP   = OP_BYPASS;
`endif

    logic                test_logic_reset;
    logic                reset_next;
    logic                capture_dr;
    logic                shift_dr;
    logic                update_dr;
    logic                capture_ir;
    logic                shift_ir;
    logic                update_ir;

    logic [IR_WIDTH-1:0] ir_shift;
    logic [IR_WIDTH-1:0] ir_reg;
    logic                bypass_reg;
    logic [DR_WIDTH-1:0] user_shift;
    logic [NUM_DR-1:0]   user_sel;
    logic                dr_tdo;

    jtag_tap_fsm u_fsm (
        .tck              (tck),
        .trstn            (trstn),
        .tms              (tms),
        .test_logic_reset (test_logic_reset),
        .reset_next       (reset_next),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .capture_ir       (capture_ir),
        .shift_ir         (shift_ir),
        .update_ir        (update_ir)
    );

    assign tap_reset = test_logic_reset;
    assign ir_out    = ir_reg;

    // Unrecognised opcodes leave every select low and fall through to bypass.
    always_comb begin
        user_sel = '0;
        for (int i = 0; i < NUM_DR; i++) begin
            user_sel[i] = (ir_reg == IR_WIDTH'(user_op(i)));
        end
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            ir_shift <= '0;
            ir_reg   <= RESET_OP;
        end else begin
            if (capture_ir)    ir_shift <= IR_CAPTURE;
            else if (shift_ir) ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};

            // Reload on the edge that enters test-logic-reset, and hold there.
            if (reset_next)     ir_reg <= RESET_OP;
            else if (update_ir) ir_reg <= ir_shift;
        end
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            bypass_reg <= 1'b0;
            user_shift <= '0;
        end else if (capture_dr) begin
            bypass_reg <= 1'b0;
            for (int i = 0; i < NUM_DR; i++) begin
                if (user_sel[i]) user_shift <= dr_capture_data[i*DR_WIDTH +: DR_WIDTH];
            end
        end else if (shift_dr) begin
            bypass_reg <= tdi;
            user_shift <= {tdi, user_shift[DR_WIDTH-1:1]};
        end
    end

`ifdef JTAG_TAP_IDCODE_EN
    logic        idcode_sel;
    logic [31:0] idcode_shift;

    assign idcode_sel = (ir_reg == OP_IDCODE);

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn)          idcode_shift <= '0;
        else if (capture_dr) idcode_shift <= IDCODE_VAL;
        else if (shift_dr)   idcode_shift <= {tdi, idcode_shift[31:1]};
    end
`endif

    always_comb begin
        dr_tdo = bypass_reg;
        if (|user_sel) dr_tdo = user_shift[0];
`ifdef JTAG_TAP_IDCODE_EN
        if (idcode_sel) dr_tdo = idcode_shift[0];
`endif
    end

    always_ff @(posedge tck or negedge trstn) begin
        if (!trstn) begin
            dr_update_data  <= '0;
            dr_update_valid <= '0;
        end else begin
            dr_update_valid <= '0;
            if (update_dr && (|user_sel)) begin
                dr_update_data  <= user_shift;
                dr_update_valid <= user_sel;
            end
        end
    end

    always_ff @(negedge tck or negedge trstn) begin
        if (!trstn) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= shift_ir | shift_dr;
            if (shift_ir)      tdo <= ir_shift[0];
            else if (shift_dr) tdo <= dr_tdo;
            else               tdo <= 1'b0;
        end
    end

endmodule
